lane_bus_deserializer: RTL and testbench

Multi-lane serial-to-parallel converter, successor to the single-lane bus deserializer. LANES serial inputs are shifted in lock-step. Word boundaries are found by hunting for SYNC_WORD on lane 0. Assembled words are presented on a valid/ready interface to the downstream logical-layer block. Adds bit-order selection, explicit framing, backpressure and overflow reporting.

---
 rtl/lane_bus_deserializer_pkg.sv | 16 +
 rtl/lane_bus_deserializer_shift_reg.sv | 39 +++
 rtl/lane_bus_deserializer.sv | 146 ++++++++++++++
 tb/tb_lane_bus_deserializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_bus_deserializer_pkg.sv
// Shared types and constants for the multi-lane bus deserializer.
package lane_deser_pkg;

  // Framing state: hunting for the sync word on lane 0, or word-aligned.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } deser_state_t;

  // Default alignment pattern expected on lane 0.
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hBC;

  // Width of the optional status counters.
  localparam int STAT_W = 16;

endpackage

// File: rtl/lane_bus_deserializer_shift_reg.sv
// Per-lane serial shifter. MSB_FIRST selects whether the first received bit
// ends up in the word MSB (left shift) or in the word LSB (right shift).
// next_sr is the post-shift value so the framing logic can match and capture
// a word on the same edge that samples its last bit.
module lane_shift_reg #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] next_sr
);

  logic [DATA_WIDTH-1:0] sr;

  // Post-shift value for the selected bit order.
  always_comb begin
    if (MSB_FIRST) begin
      next_sr = {sr[DATA_WIDTH-2:0], bit_in};
    end else begin
      next_sr = {bit_in, sr[DATA_WIDTH-1:1]};
    end
  end

  // Shift register: cleared by reset or resync, advances on enabled edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= next_sr;
    end
  end

endmodule

// File: rtl/lane_bus_deserializer.sv
// Multi-lane serial-to-parallel converter. All lanes shift in lock-step;
// word boundaries come from SYNC_WORD detected on lane 0. Completed words go
// out through a single-entry holding register on a valid/ready interface;
// a word completing while the held word is still unconsumed is dropped and
// reported on overflow.
// Optional build macro: LANE_DESER_STATUS_EN adds saturating word_cnt and
// drop_cnt status outputs.
module lane_bus_deserializer
  import lane_deser_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LANES      = 2,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DATA_WIDTH'(DEFAULT_SYNC_WORD),
  parameter int                    MSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          resync,
  input  logic [LANES-1:0]              serial_in,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          locked,
`ifdef LANE_DESER_STATUS_EN
  output logic [STAT_W-1:0]             word_cnt,
  output logic [STAT_W-1:0]             drop_cnt,
`endif
  output logic                          overflow
);

  localparam int              CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);

  deser_state_t state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [LANES-1:0][DATA_WIDTH-1:0] next_sr_all;
  logic word_done;
  logic consume;
  logic load;
  logic drop;
  logic out_valid_nxt;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .MSB_FIRST  (MSB_FIRST != 0)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .shift_en (enable),
      .clear    (resync),
      .bit_in   (serial_in[l]),
      .next_sr  (next_sr_all[l])
    );
  end

  // Framing next-state and bit counter; resync overrides any word completion.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    word_done = 1'b0;
    if (resync) begin
      state_nxt = HUNT;
      cnt_nxt   = '0;
    end else if (enable) begin
      case (state_q)
        HUNT: begin
          if (next_sr_all[0] == SYNC_WORD) begin
            state_nxt = LOCKED;
            cnt_nxt   = '0;
          end
        end
        LOCKED: begin
          if (cnt_q == CNT_LAST) begin
            cnt_nxt   = '0;
            word_done = 1'b1;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        default: begin
          state_nxt = HUNT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Holding-register handshake: load when empty or draining this cycle.
  always_comb begin
    consume       = out_valid && out_ready;
    load          = word_done && (!out_valid || out_ready);
    drop          = word_done && out_valid && !out_ready;
    out_valid_nxt = out_valid;
    if (load) begin
      out_valid_nxt = 1'b1;
    end else if (consume) begin
      out_valid_nxt = 1'b0;
    end
  end

  // Framing state, counter, holding register and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      out_valid <= out_valid_nxt;
      overflow  <= drop;
      if (load) begin
        out_data <= next_sr_all;
      end
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef LANE_DESER_STATUS_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Status counters: words accepted into the holding register and words dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (load) begin
        word_cnt <= sat_inc(word_cnt);
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lane_bus_deserializer.sv
// Directed bench for lane_bus_deserializer: an MSB-first instance (dut) and
// an LSB-first instance (dut_lsb) share clock and control inputs.
module tb_lane_bus_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        resync = 1'b0;
  logic        out_ready = 1'b0;
  logic        ready2 = 1'b0;
  logic [1:0]  serial_in = 2'b00;
  logic [1:0]  serial_in2 = 2'b00;
  logic [15:0] out_data, out_data2;
  logic        out_valid, out_valid2;
  logic        locked, locked2;
  logic        overflow, overflow2;
`ifdef LANE_DESER_STATUS_EN
  logic [15:0] word_cnt, drop_cnt, word_cnt2, drop_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int vld_seen = 0;

  always #5 clk = ~clk;

  lane_bus_deserializer #(
    .DATA_WIDTH (8), .LANES (2), .SYNC_WORD (8'hBC), .MSB_FIRST (1)
  ) dut (
    .clk (clk), .rst (rst), .enable (enable), .resync (resync),
    .serial_in (serial_in), .out_data (out_data), .out_valid (out_valid),
    .out_ready (out_ready), .locked (locked),
`ifdef LANE_DESER_STATUS_EN
    .word_cnt (word_cnt), .drop_cnt (drop_cnt),
`endif
    .overflow (overflow)
  );

  lane_bus_deserializer #(
    .DATA_WIDTH (8), .LANES (2), .SYNC_WORD (8'hBC), .MSB_FIRST (0)
  ) dut_lsb (
    .clk (clk), .rst (rst), .enable (enable), .resync (resync),
    .serial_in (serial_in2), .out_data (out_data2), .out_valid (out_valid2),
    .out_ready (ready2), .locked (locked2),
`ifdef LANE_DESER_STATUS_EN
    .word_cnt (word_cnt2), .drop_cnt (drop_cnt2),
`endif
    .overflow (overflow2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (overflow)  ovf_seen++;
    if (out_valid) vld_seen++;
  endtask

  task automatic send_bit(input logic b0, input logic b1);
    serial_in = {b1, b0};
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic send_bit_lsb(input logic b0);
    serial_in2 = {1'b0, b0};
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Sends the top nbits of w0/w1 MSB first on lanes 0/1.
  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input int nbits = 8);
    for (int i = 7; i >= 8 - nbits; i--) send_bit(w0[i], w1[i]);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; resync = 1'b0; out_ready = 1'b0; ready2 = 1'b0;
    serial_in = 2'b00; serial_in2 = 2'b00;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", out_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid_lsb: got %b expected 0", out_valid2); end
    rst = 1'b1;
  endtask

  task automatic test_alignment();
    do_reset();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_word(8'hBC, 8'h00, 7);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL align_early_lock: got %b expected 0", locked); end
    send_bit(1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL align_lock: got %b expected 1", locked); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL align_sync_not_emitted: got %b expected 0", out_valid); end
    send_word(8'h5A, 8'hC3, 7);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL align_valid_early: got %b expected 0", out_valid); end
    send_bit(1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL align_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 16'hC35A) begin errors++; $display("FAIL align_data: got %h expected c35a", out_data); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL align_consume: got %b expected 0", out_valid); end
  endtask

  task automatic test_bit_order();
    logic [7:0] v;
    do_reset();
    v = 8'hBC;
    for (int i = 0; i < 7; i++) send_bit_lsb(v[i]);
    checks++; if (locked2 !== 1'b0) begin errors++; $display("FAIL lsb_early_lock: got %b expected 0", locked2); end
    send_bit_lsb(v[7]);
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL lsb_lock: got %b expected 1", locked2); end
    v = 8'h01;
    for (int i = 0; i < 8; i++) send_bit_lsb(v[i]);
    checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b expected 1", out_valid2); end
    checks++; if (out_data2 !== 16'h0001) begin errors++; $display("FAIL lsb_data: got %h expected 0001", out_data2); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    send_word(8'hBC, 8'h00);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL b2b_lock: got %b expected 1", locked); end
    out_ready = 1'b1;
    ovf_seen = 0;
    vld_seen = 0;
    for (int k = 0; k < 4; k++) begin
      send_word(words[k], 8'h00);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", k, out_valid); end
      checks++; if (out_data !== {8'h00, words[k]}) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, out_data, {8'h00, words[k]}); end
    end
    idle(1);
    out_ready = 1'b0;
    checks++; if (vld_seen !== 4) begin errors++; $display("FAIL b2b_transfers: got %0d expected 4", vld_seen); end
    checks++; if (ovf_seen !== 0) begin errors++; $display("FAIL b2b_overflow: got %0d expected 0", ovf_seen); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_word(8'hBC, 8'h00);
    send_word(8'hA5, 8'h0F);
    checks++; if (out_data !== 16'h0FA5) begin errors++; $display("FAIL bp_first: got %h expected 0fa5", out_data); end
    ovf_seen = 0;
    send_word(8'h3C, 8'hF0, 7);
    checks++; if (ovf_seen !== 0) begin errors++; $display("FAIL bp_early_ovf: got %0d expected 0", ovf_seen); end
    send_bit(1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_pulse: got %b expected 1", overflow); end
    checks++; if (out_data !== 16'h0FA5) begin errors++; $display("FAIL bp_held: got %h expected 0fa5", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b expected 1", out_valid); end
    idle(1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_single: got %b expected 0", overflow); end
`ifdef LANE_DESER_STATUS_EN
    checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL bp_word_cnt: got %0d expected 1", word_cnt); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer: got %b expected 0", out_valid); end
    idle(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_second: got %b expected 0", out_valid); end
  endtask

  task automatic test_enable_resync();
    logic [7:0] v;
    do_reset();
    send_word(8'hBC, 8'h00);
    v = 8'h96;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], 1'b0);
      if (i == 5 || i == 2) idle(3);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 16'h0096) begin errors++; $display("FAIL gap_data: got %h expected 0096", out_data); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_lock: got %b expected 1", locked); end
    ovf_seen = 0;
    send_word(8'hFF, 8'hFF, 4);
    resync = 1'b1;
    idle(1);
    resync = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rs_unlock: got %b expected 0", locked); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rs_pending: got %b expected 1", out_valid); end
    send_word(8'hFF, 8'hFF, 4);
    checks++; if (out_data !== 16'h0096) begin errors++; $display("FAIL rs_partial_discard: got %h expected 0096", out_data); end
    checks++; if (ovf_seen !== 0) begin errors++; $display("FAIL rs_overflow: got %0d expected 0", ovf_seen); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_transfer: got %b expected 0", out_valid); end
    send_word(8'hBC, 8'h00);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rs_relock: got %b expected 1", locked); end
    send_word(8'h77, 8'h00);
    checks++; if (out_data !== 16'h0077) begin errors++; $display("FAIL rs_next_word: got %h expected 0077", out_data); end
    send_word(8'h55, 8'h55, 7);
    resync = 1'b1;
    send_bit(1'b1, 1'b1);
    resync = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rs_coincide_ovf: got %b expected 0", overflow); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rs_coincide_lock: got %b expected 0", locked); end
    checks++; if (out_data !== 16'h0077) begin errors++; $display("FAIL rs_coincide_data: got %h expected 0077", out_data); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    send_word(8'hBC, 8'h00);
    send_word(8'h42, 8'h24);
    checks++; if (out_data !== 16'h2442) begin errors++; $display("FAIL rm_word: got %h expected 2442", out_data); end
    send_word(8'h99, 8'h99, 5);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rm_data: got %h expected 0000", out_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rm_locked: got %b expected 0", locked); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow: got %b expected 0", overflow); end
`ifdef LANE_DESER_STATUS_EN
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rm_word_cnt: got %0d expected 0", word_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rm_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    send_word(8'h42, 8'h00);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_hunt_no_word: got %b expected 0", out_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rm_hunt: got %b expected 0", locked); end
  endtask

  initial begin
    test_reset();
    test_alignment();
    test_bit_order();
    test_back_to_back();
    test_backpressure();
    test_enable_resync();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
